// File: rtl/app_stream_receiver.sv
// Receiving end of the application-injection flit stream: classifies each flit,
// tags it with its task index and forwards it through a one-deep output register.
// Optional macro APP_RECV_TAG_CHECK_EN flags any TAG word that is not all-ones.
module app_stream_receiver #(
  parameter int FLIT_SIZE  = 32,
  parameter int TASK_IDX_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic [FLIT_SIZE-1:0]  data_i,
  output logic                  credit_o,
  input  logic                  eoa_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [3:0]            out_kind_o,
  output logic [FLIT_SIZE-1:0]  out_data_o,
  output logic [TASK_IDX_W-1:0] out_task_o,
  output logic                  app_done_o,
  output logic                  all_done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  // State codes double as the field code reported on out_kind_o.
  localparam logic [3:0] S_DSIZE = 4'd0;
  localparam logic [3:0] S_TCNT  = 4'd1;
  localparam logic [3:0] S_MAP   = 4'd2;
  localparam logic [3:0] S_TAG   = 4'd3;
  localparam logic [3:0] S_DESCR = 4'd4;
  localparam logic [3:0] S_TEXT  = 4'd5;
  localparam logic [3:0] S_DATA  = 4'd6;
  localparam logic [3:0] S_BSS   = 4'd7;
  localparam logic [3:0] S_ENTRY = 4'd8;
  localparam logic [3:0] S_BIN   = 4'd9;

  localparam logic [FLIT_SIZE-1:0] ONE = FLIT_SIZE'(1);

  logic [3:0]           state_q, state_d;
  logic [FLIT_SIZE-1:0] dsize_q, tcnt_q, cnt_q, task_q, text_q, sum_q;
  logic [FLIT_SIZE-1:0] task_nx, cnt_nx, bin_words;
  logic                 last_task, last_descr, last_bin;
  logic                 accept, tag_err;
  logic                 out_valid_q, app_done_q, err_q;

  assign credit_o   = !rst_i && (!out_valid_q || out_ready_i);
  assign accept     = rx_i && credit_o;
  assign task_nx    = task_q + ONE;
  assign cnt_nx     = cnt_q + ONE;
  assign bin_words  = sum_q >> 2;
  assign last_task  = (task_nx == tcnt_q);
  assign last_descr = (cnt_nx == dsize_q);
  assign last_bin   = (cnt_nx == bin_words);

`ifdef APP_RECV_TAG_CHECK_EN
  assign tag_err = accept && (state_q == S_TAG) && (data_i != '1);
`else
  assign tag_err = 1'b0;
`endif

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_DSIZE: state_d = S_TCNT;
        S_TCNT: begin
          if (data_i != '0)        state_d = S_MAP;
          else if (dsize_q != '0)  state_d = S_DESCR;
          else                     state_d = S_DSIZE;
        end
        S_MAP: state_d = S_TAG;
        S_TAG: begin
          if (!last_task)          state_d = S_MAP;
          else if (dsize_q != '0)  state_d = S_DESCR;
          else if (tcnt_q != '0)   state_d = S_TEXT;
          else                     state_d = S_DSIZE;
        end
        S_DESCR: begin
          if (last_descr) state_d = (tcnt_q != '0) ? S_TEXT : S_DSIZE;
        end
        S_TEXT:  state_d = S_DATA;
        S_DATA:  state_d = S_BSS;
        S_BSS:   state_d = S_ENTRY;
        S_ENTRY: begin
          if (bin_words != '0) state_d = S_BIN;
          else                 state_d = last_task ? S_DSIZE : S_TEXT;
        end
        S_BIN: begin
          if (last_bin) state_d = last_task ? S_DSIZE : S_TEXT;
        end
        default: state_d = S_DSIZE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_DSIZE;
      dsize_q     <= '0;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      task_q      <= '0;
      text_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_kind_o  <= '0;
      out_data_o  <= '0;
      out_task_o  <= '0;
      app_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      app_done_q <= accept && (state_q != S_DSIZE) && (state_d == S_DSIZE);
      if ((eoa_i && (state_q != S_DSIZE)) || tag_err) err_q <= 1'b1;

      if (accept) begin
        out_valid_q <= 1'b1;
        out_kind_o  <= state_q;
        out_data_o  <= data_i;
        out_task_o  <= (state_q == S_DSIZE || state_q == S_TCNT || state_q == S_DESCR)
                       ? '0 : task_q[TASK_IDX_W-1:0];
        case (state_q)
          S_DSIZE: dsize_q <= data_i;
          S_TCNT: begin
            tcnt_q <= data_i;
            task_q <= '0;
            cnt_q  <= '0;
          end
          S_TAG: begin
            task_q <= last_task ? '0 : task_nx;
            cnt_q  <= '0;
          end
          S_DESCR: cnt_q  <= cnt_nx;
          S_TEXT:  text_q <= data_i;
          S_DATA:  sum_q  <= text_q + data_i;
          S_ENTRY: begin
            cnt_q <= '0;
            if (bin_words == '0 && !last_task) task_q <= task_nx;
          end
          S_BIN: begin
            cnt_q <= cnt_nx;
            if (last_bin && !last_task) task_q <= task_nx;
          end
          default: ;
        endcase
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign app_done_o  = app_done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_DSIZE);
  assign all_done_o  = !rst_i && eoa_i && (state_q == S_DSIZE) && !out_valid_q;

endmodule

// File: doc/app_stream_receiver.md
# app_stream_receiver

Receiving end of the application-injection flit stream. Sits at the NoC-side injection port and consumes, word by word, the credit-handshaked stream of application descriptors and task binaries. Classifies every flit by protocol field, tags it with its task index, and forwards it through a one-deep registered output to the kernel-side loader. Flags protocol errors and signals application and stream completion.

## Interface
- FLIT_SIZE, 32, flit and data width in bits (≥ 16)
- TASK_IDX_W, 8, width of the task index output
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- rx_i  in  1  sender has a valid flit on data_i
- data_i  in  FLIT_SIZE  flit payload
- credit_o  out  1  receiver accepts a flit this cycle
- eoa_i  in  1  sender end-of-applications level
- out_valid_o  out  1  registered word valid
- out_ready_i  in  1  downstream accepts the word
- out_kind_o  out  4  field code: 0 DSIZE, 1 TCNT, 2 MAP, 3 TAG, 4 DESCR, 5 TEXT, 6 DATA, 7 BSS, 8 ENTRY, 9 BIN
- out_data_o  out  FLIT_SIZE  flit payload
- out_task_o  out  TASK_IDX_W  task index of the word; 0 for DSIZE, TCNT and DESCR
- app_done_o  out  1  one-cycle pulse after the last flit of an application is accepted
- all_done_o  out  1  level: eoa_i high while FSM is in S_DSIZE and the output is empty
- busy_o  out  1  FSM is not in S_DSIZE
- err_o  out  1  sticky protocol error

## Operation
- Transfer occurs on a rising edge when rx_i && credit_o.
- credit_o = !rst_i && (!out_valid_q || out_ready_i).
- Each accepted flit loads the output register and advances the FSM.
- FSM states and per-flit transitions:
  - S_DSIZE: latch dsize → S_TCNT.
  - S_TCNT: latch tcnt. If tcnt = 0 → S_DESCR, or S_DSIZE if dsize = 0 as well.
  - S_MAP → S_TAG.
  - S_TAG: next task → S_MAP; after tcnt pairs → S_DESCR, or directly to S_TEXT (tcnt > 0) / S_DSIZE (tcnt = 0) when dsize = 0.
  - S_DESCR: after dsize words → S_TEXT if tcnt > 0, else S_DSIZE.
  - S_TEXT: latch text.
  - S_DATA: sum = (text + data) mod 2^FLIT_SIZE.
  - S_BSS.
  - S_ENTRY: bin_words = sum >> 2 (floor). → S_BIN, or skip to the next-task decision if 0.
  - S_BIN: after bin_words words, next task → S_TEXT; last task → S_DSIZE.
- Task index counts from 0 in both the MAP/TAG phase and the TEXT..BIN phase; it wraps at 2^TASK_IDX_W. Internal counters are FLIT_SIZE wide.
- app_done_o pulses on the accept that returns the FSM to S_DSIZE.
- rx_i low mid-application: FSM and counters hold indefinitely, no error.
- eoa_i high while busy_o: err_o set.

## Timing
- Reset values: out_valid_o 0, out_kind_o 0, out_data_o 0, out_task_o 0, app_done_o 0, all_done_o 0, busy_o 0, err_o 0, credit_o 0.
- Latency: flit accepted at edge N appears on out_* after edge N and holds until out_valid_o && out_ready_i.
- Throughput: 1 flit/cycle while out_ready_i stays high.
- out_ready_i low with out_valid_o high: credit_o 0, out_* stable.
- Simultaneous drain and accept in one cycle: the new word replaces the old one; out_valid_o stays 1.
- Reset asserted mid-application: FSM → S_DSIZE, pending word dropped, err_o cleared.

## Configuration
- APP_RECV_TAG_CHECK_EN defined:
  - S_TAG compares data_i with all-ones.
  - On mismatch, err_o is set. The word is still forwarded and the FSM still advances.
- Not defined: tag words are forwarded unchecked and err_o is only set by eoa_i while busy.

## Test plan
- One app, dsize=3, tcnt=1, map=0x0102, tag=0xFFFFFFFF, descr 7,8,9, text=8, data=4, bss=0x10, entry=0x100, 3 bin words, out_ready_i=1 → 14 words with kinds 0,1,2,3,4,4,4,5,6,7,8,9,9,9; app_done_o pulses once; busy_o returns to 0.
- Same stream with out_ready_i toggling every cycle → identical output sequence; credit_o low whenever out_valid_o && !out_ready_i; no word lost or duplicated.
- Two tasks: task 0 text+data=0 and task 1 text=6, data=0 → task 0 has no BIN words; task 1 emits 1 BIN word with out_task_o=1.
- dsize=0, tcnt=0 → two words accepted, then app_done_o pulses; a second app follows immediately without stall.
- Tag word 0x0 with APP_RECV_TAG_CHECK_EN → err_o=1 stays high and parsing continues. Without the macro → err_o=0.
- Reset pulse during S_BIN, then a fresh app → first output has kind 0. Then eoa_i=1 while idle → all_done_o=1.
